beacon_tx_sched: RTL and testbench



---
 rtl/beacon_tx_sched.sv | 197 +++++++++++++++++++
 tb/tb_beacon_tx_sched.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/beacon_tx_sched.sv
// Round-robin scheduler sharing one Manchester serial pin between NREQ requesters.
// Optional heartbeat frames on an idle line when BEACON_HEARTBEAT_EN is defined.
//   state | meaning
//   IDLE  | line low, waiting for a request (or heartbeat slot)
//   SEND  | serialising the 15-bit frame, two half-bits per bit
//   GAP   | line low, busy held for GAP_CYC cycles
module beacon_tx_sched #(
  parameter int NREQ     = 4,
  parameter int HALF_CYC = 1,
  parameter int GAP_CYC  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] data,
  output logic [NREQ-1:0]   ack,
  output logic              signal,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  localparam logic [15:0] HALF_LOAD = 16'(HALF_CYC - 1);
  localparam logic [15:0] GAP_LOAD  = 16'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [2:0]  NREQ_L    = 3'(NREQ);

  state_t          state_q, state_d;
  logic [14:0]     shift_q, shift_d;
  logic [3:0]      bit_q, bit_d;
  logic            half_q, half_d;
  logic            last_q, last_d;
  logic [15:0]     tmr_q, tmr_d;
  logic [15:0]     gap_q, gap_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            sig_q, sig_d;
  logic            busy_q, busy_d;

  logic [7:0]      req_pad;
  logic [63:0]     data_pad;
  logic            gnt_vld;
  logic [2:0]      gnt_idx;
  logic [3:0]      cand;
  logic            idle_edge;

`ifdef BEACON_HEARTBEAT_EN
  logic [7:0]      hb_cnt_q, hb_cnt_d;
  logic            hb_frame_q, hb_frame_d;
`endif

  assign req_pad  = 8'(req);
  assign data_pad = 64'(data);

  // Scan downwards so the lowest offset from the pointer wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = {1'b0, ptr_q} + 4'(i);
      if (cand >= 4'(NREQ)) cand = cand - 4'(NREQ);
      if (req_pad[cand[2:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[2:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    half_d    = half_q;
    last_d    = last_q;
    tmr_d     = tmr_q;
    gap_d     = gap_q;
    ptr_d     = ptr_q;
    ack_d     = '0;
    sig_d     = sig_q;
    busy_d    = busy_q;
    idle_edge = 1'b0;
`ifdef BEACON_HEARTBEAT_EN
    hb_cnt_d   = hb_cnt_q;
    hb_frame_d = hb_frame_q;
`endif

    case (state_q)
      IDLE: idle_edge = 1'b1;
      SEND: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - 16'd1;
        end else if (last_q) begin
          sig_d = 1'b0;
`ifdef BEACON_HEARTBEAT_EN
          if (hb_frame_q) hb_cnt_d = hb_cnt_q + 8'd1;
`endif
          if (GAP_CYC > 0) begin
            state_d = GAP;
            gap_d   = GAP_LOAD;
          end else begin
            idle_edge = 1'b1;
          end
        end else begin
          sig_d  = shift_q[14] ^ half_q;
          tmr_d  = HALF_LOAD;
          half_d = ~half_q;
          if (half_q) begin
            shift_d = {shift_q[13:0], 1'b0};
            if (bit_q == '0) last_d = 1'b1;
            else             bit_d  = bit_q - 4'd1;
          end
        end
      end
      GAP: begin
        if (gap_q != '0) gap_d = gap_q - 16'd1;
        else             idle_edge = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // End of a frame or gap acts as the IDLE decision edge so back-to-back
    // frames keep the 30*HALF_CYC+GAP_CYC+1 period.
    if (idle_edge) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      sig_d   = 1'b0;
      if (gnt_vld) begin
        state_d = SEND;
        busy_d  = 1'b1;
        shift_d = {4'b1010, gnt_idx, data_pad[{gnt_idx, 3'b000} +: 8]};
        bit_d   = 4'd14;
        half_d  = 1'b0;
        last_d  = 1'b0;
        tmr_d   = '0;
        ack_d   = NREQ'(8'b1 << gnt_idx);
        ptr_d   = (gnt_idx == NREQ_L - 3'd1) ? 3'd0 : gnt_idx + 3'd1;
`ifdef BEACON_HEARTBEAT_EN
        hb_frame_d = 1'b0;
      end else begin
        state_d    = SEND;
        busy_d     = 1'b1;
        shift_d    = {4'b1010, 3'b111, hb_cnt_d};
        bit_d      = 4'd14;
        half_d     = 1'b0;
        last_d     = 1'b0;
        tmr_d      = '0;
        hb_frame_d = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      half_q  <= 1'b0;
      last_q  <= 1'b0;
      tmr_q   <= '0;
      gap_q   <= '0;
      ptr_q   <= '0;
      ack_q   <= '0;
      sig_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      half_q  <= half_d;
      last_q  <= last_d;
      tmr_q   <= tmr_d;
      gap_q   <= gap_d;
      ptr_q   <= ptr_d;
      ack_q   <= ack_d;
      sig_q   <= sig_d;
      busy_q  <= busy_d;
    end
  end

`ifdef BEACON_HEARTBEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_cnt_q   <= '0;
      hb_frame_q <= 1'b0;
    end else begin
      hb_cnt_q   <= hb_cnt_d;
      hb_frame_q <= hb_frame_d;
    end
  end
`endif

  assign ack    = ack_q;
  assign signal = sig_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_beacon_tx_sched.sv
// Bench for beacon_tx_sched: scoreboard of expected acks/frames checked by a line decoder.
`timescale 1ns/1ps
module tb_beacon_tx_sched;
  localparam int NREQ = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NREQ-1:0] req_a = '0, req_b = '0, ack_a, ack_b;
  logic [8*NREQ-1:0] data_a = '0, data_b = '0;
  logic            sig_a, sig_b, busy_a, busy_b;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [10:0] exp_frames[$];
  int          exp_acks[$];
  bit          chk_period = 1'b0;
  int          last_ack = -1;
  int          fstart = 0;
  int          nsamp = 0;
  int          ack0_cnt = 0;
  bit          mon_on = 1'b0;
  logic [29:0] msh = '0;

  beacon_tx_sched #(.NREQ(NREQ), .HALF_CYC(1), .GAP_CYC(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .data(data_a),
    .ack(ack_a), .signal(sig_a), .busy(busy_a)
  );

  beacon_tx_sched #(.NREQ(NREQ), .HALF_CYC(3), .GAP_CYC(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .data(data_b),
    .ack(ack_b), .signal(sig_b), .busy(busy_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [29:0] man_bits(input logic [2:0] id, input logic [7:0] pay);
    logic [14:0] b;
    logic [29:0] r;
    b = {4'b1010, id, pay};
    for (int k = 0; k < 15; k++) begin
      r[29-2*k] = b[14-k];
      r[28-2*k] = ~b[14-k];
    end
    return r;
  endfunction

  task automatic decode_a();
    logic [14:0] b;
    logic [10:0] e;
    bit ok;
    ok = 1'b1;
    for (int k = 0; k < 15; k++) begin
      b[14-k] = msh[29-2*k];
      if (msh[28-2*k] !== ~msh[29-2*k]) ok = 1'b0;
    end
    chk("manchester", 32'(ok), 32'd1);
    chk("preamble", 32'(b[14:11]), 32'hA);
    if (exp_frames.size() == 0) begin
      chk("frame_unexpected", 32'(exp_frames.size()), 32'd1);
    end else begin
      e = exp_frames.pop_front();
      chk("frame_id_data", 32'(b[10:0]), 32'(e));
      if (b[10:8] != 3'd7) chk("ack_to_signal", 32'(fstart - last_ack), 32'd1);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_on   = 1'b0;
      last_ack = -1;
    end else begin
      if (ack_a != '0) begin
        int ei;
        chk("ack_onehot", 32'($onehot(ack_a)), 32'd1);
        if (ack_a[0]) ack0_cnt++;
        if (exp_acks.size() == 0) begin
          chk("ack_unexpected", 32'(ack_a), 32'd0);
        end else begin
          ei = exp_acks.pop_front();
          chk("ack_index", 32'(ack_a), 32'd1 << ei);
        end
        if (chk_period && last_ack >= 0) chk("ack_period", 32'(cyc - last_ack), 32'd35);
        last_ack = cyc;
      end
      if (mon_on) begin
        msh = {msh[28:0], sig_a};
        nsamp++;
        if (nsamp == 30) begin
          mon_on = 1'b0;
          decode_a();
        end
      end else if (sig_a) begin
        mon_on = 1'b1;
        msh    = 30'd1;
        nsamp  = 1;
        fstart = cyc;
      end
    end
  end

  task automatic wait_ack(input bit sel_b, input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if ((sel_b ? ack_b : ack_a) != '0) got = 1'b1;
    end
    chk("ack_timeout", 32'(got), 32'd1);
  endtask

  task automatic wait_rise(input int budget, output int t);
    bit got;
    got = 1'b0;
    t   = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (sig_a) begin
        got = 1'b1;
        t   = cyc;
      end
    end
    chk("rise_timeout", 32'(got), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_acks.delete();
    exp_frames.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, bad;
    bit got;
    logic [29:0] v, gold, mb;
    logic [89:0] vb;
    gold = {8'b10011001, 6'b011001, 16'b1001100101100110};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_signal", 32'(sig_a), 32'd0);
    chk("rst_ack", 32'(ack_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    rst_n = 1'b1;

`ifdef BEACON_HEARTBEAT_EN
    exp_frames.push_back({3'd7, 8'h00});
    exp_frames.push_back({3'd7, 8'h01});
    exp_frames.push_back({3'd7, 8'h02});
    wait_rise(10, t0);
    repeat (31) @(negedge clk);
    wait_rise(20, t1);
    chk("hb_spacing_1", 32'(t1 - t0), 32'd35);
    repeat (31) @(negedge clk);
    wait_rise(20, t2);
    chk("hb_spacing_2", 32'(t2 - t1), 32'd35);
    repeat (3) @(negedge clk);
    exp_acks.push_back(3);
    exp_frames.push_back({3'd3, 8'h5C});
    data_a[31:24] = 8'h5C;
    req_a = 4'b1000;
    wait_ack(1'b0, 60, got);
    chk("hb_req_grant_time", 32'(cyc - t2), 32'd34);
    req_a = '0;
    exp_frames.push_back({3'd7, 8'h03});
    repeat (66) @(negedge clk);
    chk("hb_drain_frames", 32'(exp_frames.size()), 32'd0);
    chk("hb_drain_acks", 32'(exp_acks.size()), 32'd0);
`else
    // Single request, exact waveform
    exp_acks.push_back(2);
    exp_frames.push_back({3'd2, 8'hA5});
    data_a[23:16] = 8'hA5;
    req_a = 4'b0100;
    wait_ack(1'b0, 10, got);
    req_a = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      v[29-i] = sig_a;
    end
    chk("single_waveform", 32'(v), 32'(gold));
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (sig_a !== 1'b0 || busy_a !== 1'b1) bad++;
    end
    chk("gap_cycles", 32'(bad), 32'd0);
    @(negedge clk);
    chk("busy_after_gap", 32'(busy_a), 32'd0);

    // Contention, all requesters held
    do_reset();
    data_a = 32'hD4C3B2A1 ^ $urandom();
    for (int i = 0; i < 5; i++) begin
      exp_acks.push_back(i % 4);
      exp_frames.push_back({3'(i % 4), data_a[8*(i%4) +: 8]});
    end
    chk_period = 1'b1;
    req_a = '1;
    for (int i = 0; i < 5; i++) wait_ack(1'b0, 40, got);
    req_a = '0;
    repeat (40) @(negedge clk);
    chk_period = 1'b0;
    chk("rr_drain_acks", 32'(exp_acks.size()), 32'd0);
    chk("rr_drain_frames", 32'(exp_frames.size()), 32'd0);

    // Reset mid-frame, then pointer restarts at 0
    exp_acks.push_back(1);
    req_a = 4'b0010;
    wait_ack(1'b0, 10, got);
    req_a = '0;
    repeat (10) @(negedge clk);
    chk("busy_mid_frame", 32'(busy_a), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_signal", 32'(sig_a), 32'd0);
    chk("async_rst_busy", 32'(busy_a), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_acks.delete();
    exp_frames.delete();
    exp_acks.push_back(1);
    exp_acks.push_back(2);
    exp_frames.push_back({3'd1, data_a[15:8]});
    exp_frames.push_back({3'd2, data_a[23:16]});
    req_a = 4'b0110;
    wait_ack(1'b0, 10, got);
    req_a = 4'b0100;
    wait_ack(1'b0, 50, got);
    req_a = '0;
    repeat (45) @(negedge clk);
    chk("rst_drain_acks", 32'(exp_acks.size()), 32'd0);
    chk("rst_drain_frames", 32'(exp_frames.size()), 32'd0);

    // Withdrawn request during SEND
    ack0_cnt = 0;
    exp_acks.push_back(2);
    exp_frames.push_back({3'd2, data_a[23:16]});
    req_a = 4'b0100;
    wait_ack(1'b0, 10, got);
    req_a = '0;
    repeat (5) @(negedge clk);
    req_a = 4'b0001;
    repeat (10) @(negedge clk);
    req_a = '0;
    repeat (60) @(negedge clk);
    chk("withdraw_no_ack0", 32'(ack0_cnt), 32'd0);
    chk("withdraw_drain_frames", 32'(exp_frames.size()), 32'd0);

    // Stretched half-bits, no gap
    data_b = {8'h00, 8'h3C, 8'h00, 8'h96};
    req_b = 4'b0101;
    wait_ack(1'b1, 10, got);
    chk("b_first_ack", 32'(ack_b), 32'd1);
    for (int i = 0; i < 90; i++) begin
      @(negedge clk);
      vb[89-i] = sig_b;
    end
    mb = man_bits(3'd0, 8'h96);
    bad = 0;
    for (int i = 0; i < 90; i++) if (vb[89-i] !== mb[29 - i/3]) bad++;
    chk("b_stretch_frame", 32'(bad), 32'd0);
    @(negedge clk);
    chk("b_next_ack", 32'(ack_b), 32'h4);
    chk("b_line_low_at_grant", 32'(sig_b), 32'd0);
    req_b = '0;
    repeat (5) @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
